multicycle_controller: RTL

- Control FSM for the multicycle RV32I core; replaces the single-cycle decoder.
- Sequences fetch/decode/execute/memory/writeback and drives ALUControl, using the existing ALU encoding as the consuming end of that interface.
- Consumes the ALU zero/comparison flags to resolve branches.
- Drives datapath mux selects and write enables; handshakes with unified instruction/data memory via mem_ready.

---
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       comparison,
   input  logic       mem_ready,
   output logic [3:0] ALUControl,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       illegal
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, TRAP
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_t state, state_n;
   logic   irw, pcw, rw, mw;

   // funct3/funct7b5 to ALU operation, shared by register and immediate forms
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5);
      case (f3)
         3'b000:  alu_decode = f7b5 ? 4'b0001 : 4'b0000;
         3'b001:  alu_decode = 4'b0111;
         3'b010:  alu_decode = 4'b0101;
         3'b011:  alu_decode = 4'b0110;
         3'b100:  alu_decode = 4'b0100;
         3'b101:  alu_decode = f7b5 ? 4'b1001 : 4'b1000;
         3'b110:  alu_decode = 4'b0011;
         default: alu_decode = 4'b0010;
      endcase
   endfunction

   // immediate format follows the opcode in every state
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 3'b001;
         OP_BR:   ImmSrc = 3'b010;
         OP_JAL:  ImmSrc = 3'b011;
         default: ImmSrc = 3'b000;
      endcase
   end

   // per-state datapath controls and next-state selection
   always_comb begin
      state_n    = state;
      ALUControl = 4'b0000;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      AdrSrc     = 1'b0;
      irw        = 1'b0;
      pcw        = 1'b0;
      rw         = 1'b0;
      mw         = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            irw       = mem_ready;
            pcw       = mem_ready;
            if (mem_ready) state_n = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_n = MEMADR;
               OP_R:         state_n = EXECUTER;
               OP_I:         state_n = EXECUTEI;
               OP_BR:        state_n = BRANCH;
               OP_JAL:       state_n = JAL;
               default:      state_n = TRAP;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_n = (op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_n = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            rw        = 1'b1;
            state_n   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            mw     = 1'b1;
            if (mem_ready) state_n = FETCH;
         end
         EXECUTER: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_decode(funct3, funct7b5);
            state_n    = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            // addi has no subtract form, so funct7b5 only matters for shifts
            ALUControl = alu_decode(funct3, funct7b5 & (funct3 != 3'b000));
            state_n    = (funct3 == 3'b001 && funct7b5) ? TRAP : ALUWB;
         end
         ALUWB: begin
            rw      = 1'b1;
            state_n = FETCH;
         end
         BRANCH: begin
            ALUSrcA = 2'b10;
            state_n = FETCH;
            case (funct3)
               3'b000: begin ALUControl = 4'b0001; pcw = zero;       end
               3'b001: begin ALUControl = 4'b1010; pcw = comparison; end
               3'b100: begin ALUControl = 4'b1011; pcw = comparison; end
               3'b101: begin ALUControl = 4'b1100; pcw = comparison; end
               default: state_n = TRAP;
            endcase
         end
         JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pcw     = 1'b1;
            state_n = ALUWB;
         end
         default: state_n = TRAP;
      endcase
   end

   // state register; illegal latches on entry to the terminal trap state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         illegal <= 1'b0;
      end else begin
         state <= state_n;
         if (state_n == TRAP) illegal <= 1'b1;
      end
   end

   // enables are held off for as long as reset is asserted
   assign IRWrite  = irw & rst_n;
   assign PCWrite  = pcw & rst_n;
   assign RegWrite = rw  & rst_n;
   assign MemWrite = mw  & rst_n;

endmodule
